benes_route_gen: RTL and testbench
==================================

Name: benes_route_gen

Overview:
- Control-side producer for the 8x8 Benes network: takes a destination permutation and computes the 5-stage x 4-bit switch settings that `stage_module` instances consume on `switch_set`.
- Uses the looping algorithm: outer stages first, then both 4x4 subnetworks in parallel, then the middle stage.
- Sits between the permutation source and the stage chain, with valid/ready on both sides.

Parameters:
- `N_PORT`, 8, network ports (fixed; only 8 supported)
- `PW`, 4, port-number width, matching the 4-bit data ports
- `N_STAGE`, 5, Benes stages (2*log2(8)-1)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `perm_valid`  in  1  permutation offered
- `perm_ready`  out  1  block idle, can accept
- `perm_dst`  in  [7:0][3:0]  destination port of input i
- `sw_valid`  out  1  result available
- `sw_ready`  in  1  consumer accepts result
- `sw_set`  out  [4:0][3:0]  per-stage switch settings
- `sw_err`  out  1  qualifies `sw_valid`: permutation was invalid

Behaviour:
- Reset: `perm_ready`=0 during reset, then 1 in IDLE; `sw_valid`=0, `sw_err`=0, `sw_set`=0, FSM=IDLE.
- Reset mid-operation: abort immediately, same values; no partial result is ever presented.
- Switch semantics: bit k=0 is straight (in 2k->out 2k, 2k+1->2k+1); bit k=1 is crossed.
- Wiring, 8x8: stage0 switch k out 2k -> upper subnet input k; out 2k+1 -> lower subnet input k. Upper/lower subnet output m -> stage4 switch m input 0/1.
- Wiring, 4x4 subnets: same rule recursively, 2 switches per stage, middle 2x2 switches 0/1.
- Packing:
  - `sw_set[0]`/`[4]` = input/output stage, bit k = switch k.
  - `sw_set[1]`, `[2]`, `[3]`: bits[1:0] = upper subnet, bits[3:2] = lower subnet.
- Handshake: `perm_ready`=1 only in IDLE; accept on `perm_valid`&&`perm_ready`. Permutation and inverse are registered at accept.
- Validity check on accepted data: any `perm_dst[i][3]`=1 or any duplicate destination is invalid.
  - Next cycle: `sw_valid`=1, `sw_err`=1, `sw_set`=0.
- Valid permutation, FSM IDLE -> OUTER(4) -> BUILD(1) -> INNER(2) -> MID(1) -> DONE:
  - `sw_valid` rises exactly 8 cycles after the accept edge with `sw_err`=0.
- OUTER: loop start p=0 with in_sw[0]=0 set at accept. Each cycle:
  - d=perm[p]; out_sw[d>>1]=d[0]; s=inv[d^1]; in_sw[s>>1]=~s[0]; p<=s^1.
  - If (s>>1) is the loop's start switch, the loop is closed. Then start a new loop at the lowest unset input switch j: in_sw[j]=0, p<=2j, in the same cycle.
- BUILD: derive each subnet's 4-entry permutation.
  - Upper input k carries input 2k if in_sw[k]=0, else 2k+1.
  - Its subnet destination is (dst>>1); lower subnet uses the complement.
- INNER: same looping rule on each 4x4 subnet (2 switches), both subnets in parallel, 2 cycles.
- MID: each middle switch bit is 0 iff its input 0 is routed to its output 0.
- DONE: hold `sw_set`/`sw_valid`/`sw_err` stable until `sw_ready`. On that handshake clear `sw_valid` and go to IDLE; `perm_ready` returns the next cycle.
- `sw_ready` asserted before `sw_valid` has no effect. `perm_valid` outside IDLE is ignored.
- Back-to-back: minimum 10 cycles between successive accepts (1 IDLE cycle after each result handshake).

Decomposition:
- Package `benes_pkg`: `PW`, `N_PORT`, `N_STAGE`, `port_t` (logic [3:0]), `perm_t` (port_t [7:0]), `sw_set_t` (logic [4:0][3:0]), FSM state enum.
- Sub-module `benes_loop_step`: one combinational looping step, parameterised by switch count (4 or 2). Instantiated once for OUTER and twice for INNER.

Test Plan:
- Identity `perm_dst[i]`=i -> `sw_valid` at accept+8, `sw_set`=0 in all stages, `sw_err`=0.
- Pair swap `perm_dst[i]`=i^1 -> `sw_set[4]`=4'hF, stages 0-3 = 0.
- Invalid input: `perm_dst`={0,0,2,3,4,5,6,7}, or any bit3 set -> `sw_valid`, `sw_err`=1, `sw_set`=0 at accept+1.
- Backpressure: hold `sw_ready`=0 for 20 cycles -> outputs stable, `perm_ready`=0; release -> idle next cycle, new accept succeeds.
- `rst_n` pulsed low during INNER -> outputs zero immediately, no `sw_valid`, next permutation processes normally.
- 500 random permutations -> settings applied through a 5-stage `stage_module` model deliver input i to port `perm_dst[i]`; settings match the bit-accurate reference model.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared types for the 8x8 Benes route generator.
// Port, permutation and switch-setting bundles plus FSM states.
package benes_pkg;

   localparam int N_PORT  = 8;
   localparam int PW      = 4;
   localparam int N_STAGE = 5;

   typedef logic [PW-1:0] port_t;
   typedef port_t [N_PORT-1:0] perm_t;
   typedef logic [N_STAGE-1:0][3:0] sw_set_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OUTER,
      ST_BUILD,
      ST_INNER,
      ST_MID,
      ST_DONE
   } state_t;

endpackage

// File: rtl/benes_loop_step.sv
// One combinational step of the looping algorithm.
// Sized for the 8-port outer network or a 4-port subnet.
module benes_loop_step #(
   parameter int  NSW = 4,
   localparam int IW  = $clog2(2 * NSW),
   localparam int SW  = IW - 1
) (
   input  logic [2*NSW-1:0][IW-1:0] perm,
   input  logic [2*NSW-1:0][IW-1:0] inv,
   input  logic [IW-1:0]            p,
   input  logic [SW-1:0]            start,
   input  logic [NSW-1:0]           in_sw,
   input  logic [NSW-1:0]           out_sw,
   input  logic [NSW-1:0]           done_sw,
   output logic [IW-1:0]            p_nxt,
   output logic [SW-1:0]            start_nxt,
   output logic [NSW-1:0]           in_sw_nxt,
   output logic [NSW-1:0]           out_sw_nxt,
   output logic [NSW-1:0]           done_sw_nxt
);

   logic [IW-1:0] d;
   logic [IW-1:0] s;
   logic          found;

   always_comb begin
      d           = perm[p];
      s           = inv[{d[IW-1:1], ~d[0]}];
      out_sw_nxt  = out_sw;
      in_sw_nxt   = in_sw;
      done_sw_nxt = done_sw;
      start_nxt   = start;
      found       = 1'b0;
      out_sw_nxt[d[IW-1:1]]  = d[0];
      in_sw_nxt[s[IW-1:1]]   = ~s[0];
      done_sw_nxt[s[IW-1:1]] = 1'b1;
      p_nxt = {s[IW-1:1], ~s[0]};
      // loop closed: reopen at the lowest untouched input switch
      if (s[IW-1:1] == start) begin
         for (int j = 0; j < NSW; j++) begin
            if (!found && !done_sw_nxt[j]) begin
               found          = 1'b1;
               in_sw_nxt[j]   = 1'b0;
               done_sw_nxt[j] = 1'b1;
               start_nxt      = SW'(j);
               p_nxt          = {SW'(j), 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/benes_route_gen.sv
// Looping-algorithm switch-setting generator for the 8x8 Benes network.
// Outer stages, then both 4x4 subnets in parallel, then middle stage.
module benes_route_gen
   import benes_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    perm_valid,
   output logic    perm_ready,
   input  perm_t   perm_dst,
   output logic    sw_valid,
   input  logic    sw_ready,
   output sw_set_t sw_set,
   output logic    sw_err
);

   state_t state;

   logic [7:0][2:0] perm_q, inv_q, inv_c;
   logic            bad_q, bad_c;
   logic [1:0]      cnt_q;

   logic [2:0] o_p, o_p_n;
   logic [1:0] o_start, o_start_n;
   logic [3:0] o_in, o_in_n;
   logic [3:0] o_out, o_out_n;
   logic [3:0] o_done, o_done_n;

   logic [1:0][3:0][1:0] s_perm, s_inv;
   logic [1:0][3:0][1:0] b_perm, b_inv;
   logic [1:0][1:0]      s_p, s_p_n;
   logic [1:0]           s_start, s_start_n;
   logic [1:0][1:0]      s_in, s_in_n;
   logic [1:0][1:0]      s_out, s_out_n;
   logic [1:0][1:0]      s_done, s_done_n;
   logic [1:0][1:0]      mid;
   sw_set_t              res;

   always_comb begin
      bad_c = 1'b0;
      inv_c = '0;
      for (int i = 0; i < 8; i++) begin
         bad_c = bad_c | perm_dst[i][3];
         inv_c[perm_dst[i][2:0]] = 3'(i);
         for (int j = i + 1; j < 8; j++)
            if (perm_dst[i] == perm_dst[j]) bad_c = 1'b1;
      end
   end

   benes_loop_step #(.NSW(4)) u_outer (
      .perm        (perm_q),
      .inv         (inv_q),
      .p           (o_p),
      .start       (o_start),
      .in_sw       (o_in),
      .out_sw      (o_out),
      .done_sw     (o_done),
      .p_nxt       (o_p_n),
      .start_nxt   (o_start_n),
      .in_sw_nxt   (o_in_n),
      .out_sw_nxt  (o_out_n),
      .done_sw_nxt (o_done_n)
   );

   // subnet h=0 takes the upper outputs, h=1 the complements
   always_comb begin
      b_perm = '0;
      b_inv  = '0;
      for (int k = 0; k < 4; k++) begin
         b_perm[0][k] = perm_q[{2'(k), o_in[k]}][2:1];
         b_perm[1][k] = perm_q[{2'(k), ~o_in[k]}][2:1];
      end
      for (int h = 0; h < 2; h++)
         for (int k = 0; k < 4; k++)
            b_inv[h][b_perm[h][k]] = 2'(k);
   end

   for (genvar h = 0; h < 2; h++) begin : g_sub
      benes_loop_step #(.NSW(2)) u_inner (
         .perm        (s_perm[h]),
         .inv         (s_inv[h]),
         .p           (s_p[h]),
         .start       (s_start[h]),
         .in_sw       (s_in[h]),
         .out_sw      (s_out[h]),
         .done_sw     (s_done[h]),
         .p_nxt       (s_p_n[h]),
         .start_nxt   (s_start_n[h]),
         .in_sw_nxt   (s_in_n[h]),
         .out_sw_nxt  (s_out_n[h]),
         .done_sw_nxt (s_done_n[h])
      );
      assign mid[h][0] = s_perm[h][{1'b0, s_in[h][0]}][1];
      assign mid[h][1] = s_perm[h][{1'b0, ~s_in[h][0]}][1];
   end

   assign res = {o_out, s_out, mid, s_in, o_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         perm_ready <= 1'b0;
         sw_valid   <= 1'b0;
         sw_err     <= 1'b0;
         sw_set     <= '0;
         perm_q     <= '0;
         inv_q      <= '0;
         bad_q      <= 1'b0;
         cnt_q      <= '0;
         o_p        <= '0;
         o_start    <= '0;
         o_in       <= '0;
         o_out      <= '0;
         o_done     <= '0;
         s_perm     <= '0;
         s_inv      <= '0;
         s_p        <= '0;
         s_start    <= '0;
         s_in       <= '0;
         s_out      <= '0;
         s_done     <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               perm_ready <= 1'b1;
               if (perm_valid && perm_ready) begin
                  for (int i = 0; i < 8; i++)
                     perm_q[i] <= perm_dst[i][2:0];
                  inv_q      <= inv_c;
                  bad_q      <= bad_c;
                  o_p        <= '0;
                  o_start    <= '0;
                  o_in       <= '0;
                  o_out      <= '0;
                  o_done     <= 4'b0001;
                  cnt_q      <= '0;
                  perm_ready <= 1'b0;
                  state      <= ST_OUTER;
               end
            end
            ST_OUTER: begin
               if (bad_q) begin
                  sw_valid <= 1'b1;
                  sw_err   <= 1'b1;
                  sw_set   <= '0;
                  state    <= ST_DONE;
               end else begin
                  o_p     <= o_p_n;
                  o_start <= o_start_n;
                  o_in    <= o_in_n;
                  o_out   <= o_out_n;
                  o_done  <= o_done_n;
                  cnt_q   <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) state <= ST_BUILD;
               end
            end
            ST_BUILD: begin
               s_perm  <= b_perm;
               s_inv   <= b_inv;
               s_p     <= '0;
               s_start <= '0;
               s_in    <= '0;
               s_out   <= '0;
               s_done  <= {2'b01, 2'b01};
               cnt_q   <= '0;
               state   <= ST_INNER;
            end
            ST_INNER: begin
               s_p     <= s_p_n;
               s_start <= s_start_n;
               s_in    <= s_in_n;
               s_out   <= s_out_n;
               s_done  <= s_done_n;
               cnt_q   <= cnt_q + 2'd1;
               if (cnt_q == 2'd1) state <= ST_MID;
            end
            ST_MID: begin
               sw_set   <= res;
               sw_valid <= 1'b1;
               sw_err   <= 1'b0;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (sw_ready) begin
                  sw_valid   <= 1'b0;
                  sw_err     <= 1'b0;
                  sw_set     <= '0;
                  perm_ready <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_benes_route_gen.sv
// Directed and random checks for benes_route_gen.
// Settings are checked against a looping model and a network walk.
module tb_benes_route_gen;
   import benes_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n;
   logic    perm_valid;
   logic    perm_ready;
   perm_t   perm_dst;
   logic    sw_valid;
   logic    sw_ready;
   sw_set_t sw_set;
   logic    sw_err;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   benes_route_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .perm_valid (perm_valid),
      .perm_ready (perm_ready),
      .perm_dst   (perm_dst),
      .sw_valid   (sw_valid),
      .sw_ready   (sw_ready),
      .sw_set     (sw_set),
      .sw_err     (sw_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input perm_t p, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!perm_ready && n < 40) begin
         tick();
         n++;
      end
      if (perm_ready) begin
         perm_dst   = p;
         perm_valid = 1'b1;
         tick();
         perm_valid = 1'b0;
         ok = 1'b1;
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!sw_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic ack();
      sw_ready = 1'b1;
      tick();
      sw_ready = 1'b0;
   endtask

   function automatic perm_t mk_ident();
      perm_t p;
      for (int i = 0; i < 8; i++) p[i] = 4'(i);
      return p;
   endfunction

   // switch setting of a network of n ports, loop by loop
   function automatic void loop_route(
      input int n, input int pm[8],
      output logic [3:0] isw, output logic [3:0] osw);
      int inv[8];
      bit done[4];
      int p, d, s, st;
      isw = '0;
      osw = '0;
      for (int i = 0; i < 8; i++) inv[i] = 0;
      for (int i = 0; i < n; i++) inv[pm[i]] = i;
      for (int i = 0; i < 4; i++) done[i] = 1'b0;
      for (int j = 0; j < n / 2; j++) begin
         if (!done[j]) begin
            st = j;
            done[j] = 1'b1;
            isw[j] = 1'b0;
            p = 2 * j;
            for (int g = 0; g < n; g++) begin
               d = pm[p];
               osw[d/2] = (d % 2 == 1);
               s = inv[d ^ 1];
               isw[s/2] = (s % 2 == 0);
               done[s/2] = 1'b1;
               p = s ^ 1;
               if (s / 2 == st) break;
            end
         end
      end
   endfunction

   function automatic sw_set_t ref_sw(input perm_t pd);
      int pm[8], up[8], lo[8];
      logic [3:0] i0, o0, iu, ou, il, ol;
      logic [1:0] mu, ml;
      int a;
      for (int i = 0; i < 8; i++) begin
         pm[i] = int'(pd[i][2:0]);
         up[i] = 0;
         lo[i] = 0;
      end
      loop_route(8, pm, i0, o0);
      for (int k = 0; k < 4; k++) begin
         a = 2 * k + (i0[k] ? 1 : 0);
         up[k] = pm[a] / 2;
         lo[k] = pm[a ^ 1] / 2;
      end
      loop_route(4, up, iu, ou);
      loop_route(4, lo, il, ol);
      a = iu[0] ? 1 : 0;
      mu[0] = (up[a] / 2 == 1);
      mu[1] = (up[a ^ 1] / 2 == 1);
      a = il[0] ? 1 : 0;
      ml[0] = (lo[a] / 2 == 1);
      ml[1] = (lo[a ^ 1] / 2 == 1);
      return {o0, ol[1:0], ou[1:0], ml, mu, il[1:0], iu[1:0], i0};
   endfunction

   // walk the 5 switch stages and their inter-stage wiring
   function automatic bit route_ok(input sw_set_t s, input perm_t p);
      int x[8], y[8];
      int t;
      for (int i = 0; i < 8; i++) begin
         x[i] = i;
         y[i] = 0;
      end
      for (int st = 0; st < 5; st++) begin
         for (int q = 0; q < 4; q++) begin
            if (s[st][q]) begin
               t = x[2*q];
               x[2*q] = x[2*q+1];
               x[2*q+1] = t;
            end
         end
         if (st == 0) begin
            for (int k = 0; k < 4; k++) begin
               y[k] = x[2*k];
               y[4+k] = x[2*k+1];
            end
         end else if (st == 1) begin
            for (int h = 0; h < 2; h++)
               for (int k = 0; k < 2; k++) begin
                  y[4*h+k] = x[4*h+2*k];
                  y[4*h+2+k] = x[4*h+2*k+1];
               end
         end else if (st == 2) begin
            for (int h = 0; h < 2; h++)
               for (int m = 0; m < 2; m++) begin
                  y[4*h+2*m] = x[4*h+m];
                  y[4*h+2*m+1] = x[4*h+2+m];
               end
         end else if (st == 3) begin
            for (int m = 0; m < 4; m++) begin
               y[2*m] = x[m];
               y[2*m+1] = x[4+m];
            end
         end
         if (st < 4) x = y;
      end
      for (int i = 0; i < 8; i++)
         if (x[p[i][2:0]] != i) return 1'b0;
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      perm_valid = 1'b0;
      sw_ready = 1'b0;
      perm_dst = '0;
      tick();
      tick();
      tot_cnt++;
      if ({perm_ready, sw_valid, sw_err, sw_set} !== 23'd0)
         $display("FAIL reset_outputs: got rdy=%b v=%b e=%b set=%h want 0",
                  perm_ready, sw_valid, sw_err, sw_set);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      tot_cnt++;
      if (perm_ready !== 1'b1)
         $display("FAIL reset_ready: got %b want 1", perm_ready);
      else pass_cnt++;
   endtask

   task automatic test_identity();
      bit ok;
      int lat;
      send(mk_ident(), ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 8)
         $display("FAIL ident_latency: got %0d ok=%b want 8", lat, ok);
      else pass_cnt++;
      tot_cnt++;
      if ({sw_valid, sw_err, sw_set} !== {1'b1, 1'b0, 20'h0})
         $display("FAIL ident_set: got v=%b e=%b set=%h want 1 0 00000",
                  sw_valid, sw_err, sw_set);
      else pass_cnt++;
      ack();
      tot_cnt++;
      if ({sw_valid, perm_ready} !== 2'b01)
         $display("FAIL ident_release: got v=%b rdy=%b want 0 1",
                  sw_valid, perm_ready);
      else pass_cnt++;
   endtask

   task automatic test_pair_swap();
      bit ok;
      int lat;
      perm_t p;
      for (int i = 0; i < 8; i++) p[i] = 4'(i ^ 1);
      send(p, ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 8 || sw_err !== 1'b0 || sw_set !== 20'hF0000)
         $display("FAIL pair_swap: got lat=%0d e=%b set=%h want 8 0 f0000",
                  lat, sw_err, sw_set);
      else pass_cnt++;
      ack();
   endtask

   task automatic test_invalid();
      bit ok;
      int lat;
      perm_t p;
      p = mk_ident();
      p[1] = 4'd0;
      send(p, ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 1 || {sw_valid, sw_err, sw_set} !== {2'b11, 20'h0})
         $display("FAIL invalid_dup: got lat=%0d e=%b set=%h want 1 1 00000",
                  lat, sw_err, sw_set);
      else pass_cnt++;
      ack();
      p = mk_ident();
      p[5] = 4'hD;
      send(p, ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 1 || {sw_valid, sw_err, sw_set} !== {2'b11, 20'h0})
         $display("FAIL invalid_bit3: got lat=%0d e=%b set=%h want 1 1 00000",
                  lat, sw_err, sw_set);
      else pass_cnt++;
      ack();
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      perm_t p;
      sw_set_t snap;
      for (int i = 0; i < 8; i++) p[i] = 4'(7 - i);
      send(p, ok);
      wait_valid(lat);
      snap = sw_set;
      tot_cnt++;
      if (!ok || lat !== 8 || snap !== ref_sw(p) || !route_ok(snap, p))
         $display("FAIL reverse_set: got lat=%0d set=%h want 8 %h",
                  lat, snap, ref_sw(p));
      else pass_cnt++;
      perm_dst = mk_ident();
      perm_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         tot_cnt++;
         if ({sw_valid, sw_err, perm_ready, sw_set} !== {3'b100, snap})
            $display("FAIL hold_c%0d: got v=%b e=%b rdy=%b set=%h want 1 0 0 %h",
                     c, sw_valid, sw_err, perm_ready, sw_set, snap);
         else pass_cnt++;
      end
      perm_valid = 1'b0;
      ack();
      tot_cnt++;
      if ({sw_valid, perm_ready} !== 2'b01)
         $display("FAIL bp_release: got v=%b rdy=%b want 0 1",
                  sw_valid, perm_ready);
      else pass_cnt++;
      send(mk_ident(), ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 8 || sw_set !== 20'h0 || sw_err !== 1'b0)
         $display("FAIL bp_next: got lat=%0d set=%h want 8 00000", lat, sw_set);
      else pass_cnt++;
      ack();
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int lat;
      perm_t p;
      for (int i = 0; i < 8; i++) p[i] = 4'(7 - i);
      send(p, ok);
      for (int c = 0; c < 5; c++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      tot_cnt++;
      if ({perm_ready, sw_valid, sw_err, sw_set} !== 23'd0)
         $display("FAIL midreset_outputs: got rdy=%b v=%b e=%b set=%h want 0",
                  perm_ready, sw_valid, sw_err, sw_set);
      else pass_cnt++;
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (sw_valid) seen = 1'b1;
      end
      tot_cnt++;
      if (seen !== 1'b0)
         $display("FAIL midreset_novalid: got valid seen=%b want 0", seen);
      else pass_cnt++;
      send(p, ok);
      wait_valid(lat);
      tot_cnt++;
      if (!ok || lat !== 8 || sw_set !== ref_sw(p) || !route_ok(sw_set, p))
         $display("FAIL midreset_next: got lat=%0d set=%h want 8 %h",
                  lat, sw_set, ref_sw(p));
      else pass_cnt++;
      ack();
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int val[$];
      bit r;
      int cyc = 0;
      perm_t p;
      for (int i = 0; i < 8; i++) p[i] = 4'(i ^ 1);
      perm_dst = p;
      perm_valid = 1'b1;
      sw_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         r = perm_ready;
         tick();
         cyc++;
         if (r) acc.push_back(cyc);
         if (sw_valid) begin
            val.push_back(cyc);
            tot_cnt++;
            if (sw_set !== 20'hF0000 || sw_err !== 1'b0)
               $display("FAIL b2b_set: got set=%h e=%b want f0000 0",
                        sw_set, sw_err);
            else pass_cnt++;
         end
      end
      perm_valid = 1'b0;
      sw_ready = 1'b0;
      tot_cnt++;
      if (acc.size() < 2 || val.size() < 1)
         $display("FAIL b2b_count: got acc=%0d val=%0d want >=2 >=1",
                  acc.size(), val.size());
      else if (acc[1] - acc[0] !== 10 || val[0] - acc[0] !== 8)
         $display("FAIL b2b_timing: got gap=%0d lat=%0d want 10 8",
                  acc[1] - acc[0], val[0] - acc[0]);
      else pass_cnt++;
      tot_cnt++;
      if (val.size() !== 3)
         $display("FAIL b2b_results: got %0d want 3", val.size());
      else pass_cnt++;
      tick();
   endtask

   task automatic test_random();
      bit ok;
      int lat;
      int a[8];
      int j, t;
      perm_t p;
      sw_set_t exp_set;
      for (int it = 0; it < 500; it++) begin
         for (int i = 0; i < 8; i++) a[i] = i;
         for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = a[i];
            a[i] = a[j];
            a[j] = t;
         end
         for (int i = 0; i < 8; i++) p[i] = 4'(a[i]);
         exp_set = ref_sw(p);
         send(p, ok);
         wait_valid(lat);
         tot_cnt++;
         if (!ok || lat !== 8 || sw_err !== 1'b0)
            $display("FAIL rnd%0d_timing: got lat=%0d e=%b want 8 0",
                     it, lat, sw_err);
         else pass_cnt++;
         tot_cnt++;
         if (sw_set !== exp_set)
            $display("FAIL rnd%0d_model: got %h want %h", it, sw_set, exp_set);
         else pass_cnt++;
         tot_cnt++;
         if (!route_ok(sw_set, p))
            $display("FAIL rnd%0d_route: got set=%h perm=%h want delivered",
                     it, sw_set, p);
         else pass_cnt++;
         ack();
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_pair_swap();
      test_invalid();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
